// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port frame-buffer arbiter, display reads > block clear > writer.
// Define VBLANK_ONLY_WR_EN to restrict writer stores to vertical blanking.
module vram_arbiter #(
   parameter int ADDR_W = 17,
   parameter int DEPTH  = 76800
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              video_on,
   input  logic              vblank,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_valid,
   output logic [2:0]        disp_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [2:0]        wr_data,
   input  logic              clr_start,
   input  logic [2:0]        clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [2:0]        ram_wdata,
   input  logic [2:0]        ram_rdata
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLEAR = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic [2:0]        color;
   logic              rd_p, rd_inr;
   logic              dreq, disp_inr, wr_inr, clr_slot, wr_go, vb_ok;

   assign dreq     = disp_req & video_on;
   assign disp_inr = disp_addr <= LAST;
   assign wr_inr   = wr_addr <= LAST;
`ifdef VBLANK_ONLY_WR_EN
   assign vb_ok = vblank;
`else
   // vblank has no effect on the writer in this build
   assign vb_ok = vblank | 1'b1;
`endif
   assign wr_ready = ~reset & ~dreq & (state == IDLE) & vb_ok;
   assign clr_slot = ~reset & ~dreq & (state == CLEAR);
   assign wr_go    = wr_valid & wr_ready & wr_inr;
   assign clr_busy = state == CLEAR;
   assign clr_done = state == DONE;

   always_comb begin
      ram_en    = ~reset & (dreq ? disp_inr : (clr_slot | wr_go));
      ram_we    = ~reset & ~dreq & (clr_slot | wr_go);
      ram_addr  = dreq ? disp_addr : clr_slot ? cnt : wr_addr;
      ram_wdata = clr_slot ? color : wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         color <= '0;
      end else if (state == IDLE && clr_start) begin
         state <= CLEAR;
         cnt   <= '0;
         color <= clr_color;
      end else if (clr_slot) begin
         if (cnt == LAST) state <= DONE;
         else cnt <= cnt + 1'b1;
      end else if (state[1]) begin
         state <= IDLE;
      end
   end

   // Out-of-range reads still produce a strobe, with the pixel forced to 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_p       <= 1'b0;
         rd_inr     <= 1'b0;
         disp_valid <= 1'b0;
         disp_data  <= 3'b0;
      end else begin
         rd_p       <= dreq;
         rd_inr     <= dreq & disp_inr;
         disp_valid <= rd_p;
         disp_data  <= rd_inr ? ram_rdata : 3'b0;
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter at DEPTH=16 with a behavioural RAM.
module tb_vram_arbiter;
   localparam int AW = 17;
   localparam int D  = 16;

   logic clk = 0, reset = 1, video_on = 0, vblank = 1, disp_req = 0, wr_valid = 0, clr_start = 0;
   logic [AW-1:0] disp_addr = '0, wr_addr = '0;
   logic [2:0] wr_data = '0, clr_color = '0;
   logic disp_valid, wr_ready, clr_busy, clr_done, ram_en, ram_we;
   logic [2:0] disp_data, ram_wdata;
   logic [2:0] ram_rdata = '0;
   logic [AW-1:0] ram_addr;

   logic [2:0] mem [D];
   logic [2:0] shadow [D];
   int checks = 0, errors = 0, cyc = 0;
   typedef struct {logic [2:0] data; int due;} exp_t;
   exp_t q[$];

   vram_arbiter #(.ADDR_W(AW), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .video_on(video_on), .vblank(vblank),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ram_en && ram_addr < AW'(D)) begin
         if (ram_we) mem[ram_addr[3:0]] <= ram_wdata;
         else ram_rdata <= mem[ram_addr[3:0]];
      end
   end

   always @(negedge clk) begin
      if (disp_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: disp_valid=1 data=%0d with no read outstanding (cyc %0d)", disp_data, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (disp_data !== e.data || cyc !== e.due) begin
               errors++;
               $display("FAIL read_data: got data=%0d at cyc %0d, expected data=%0d at cyc %0d", disp_data, cyc, e.data, e.due);
            end
         end
      end
      if (ram_en === 1'b1 && ram_addr >= AW'(D)) begin
         checks++;
         errors++;
         $display("FAIL ram_range: ram_en with ram_addr=%0d, expected no access beyond %0d", ram_addr, D - 1);
      end
   end

   task automatic issue(input int a);
      exp_t e;
      disp_req = 1;
      video_on = 1;
      disp_addr = AW'(a);
      e.data = (a < D) ? shadow[a] : 3'b0;
      e.due = cyc + 2;
      q.push_back(e);
   endtask

   task automatic read_all();
      for (int i = 0; i < D; i++) begin
         @(negedge clk);
         issue(i);
      end
      @(negedge clk);
      disp_req = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wr(input int a, input logic [2:0] d);
      @(negedge clk);
      wr_valid = 1;
      wr_addr = AW'(a);
      wr_data = d;
      #1;
      checks++;
      if (wr_ready !== 1'b1 || ram_en !== (a < D) || ram_we !== (a < D) || (a < D && (ram_addr !== AW'(a) || ram_wdata !== d))) begin
         errors++;
         $display("FAIL write_%0d: ready=%b en=%b we=%b addr=%0d wdata=%0d, expected ready=1 en/we=%b addr=%0d wdata=%0d",
                  a, wr_ready, ram_en, ram_we, ram_addr, ram_wdata, a < D, a, d);
      end
      @(negedge clk);
      wr_valid = 0;
      if (a < D) shadow[a] = d;
   endtask

   task automatic test_reset();
      disp_req = 1; video_on = 1; disp_addr = AW'(2); wr_valid = 1;
      repeat (2) @(negedge clk);
      checks++;
      if (ram_en !== 0 || disp_valid !== 0 || disp_data !== 0 || clr_busy !== 0 || clr_done !== 0) begin
         errors++;
         $display("FAIL reset_hold: en=%b valid=%b data=%0d busy=%b done=%b, expected all 0", ram_en, disp_valid, disp_data, clr_busy, clr_done);
      end
      disp_req = 0; wr_valid = 0; reset = 0;
      @(negedge clk);
      checks++;
      if (wr_ready !== 1 || disp_valid !== 0 || disp_data !== 0 || clr_busy !== 0 || clr_done !== 0 || ram_en !== 0) begin
         errors++;
         $display("FAIL reset_release: ready=%b valid=%b data=%0d busy=%b done=%b en=%b, expected ready=1 rest 0",
                  wr_ready, disp_valid, disp_data, clr_busy, clr_done, ram_en);
      end
   endtask

   task automatic test_write_read();
      wr(5, 3'b101);
      wr(1, 3'b011);
      wr(30, 3'b111);
      @(negedge clk); issue(5);
      @(negedge clk); disp_req = 0;
      @(negedge clk); issue(1);
      @(negedge clk); disp_req = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_contention();
      @(negedge clk);
      wr_valid = 1; wr_addr = AW'(3); wr_data = 3'b110;
      issue(5);
      #1;
      checks++;
      if (wr_ready !== 0 || ram_we !== 0 || ram_en !== 1 || ram_addr !== AW'(5)) begin
         errors++;
         $display("FAIL contention_read: ready=%b we=%b en=%b addr=%0d, expected ready=0 we=0 en=1 addr=5", wr_ready, ram_we, ram_en, ram_addr);
      end
      @(negedge clk);
      disp_req = 0;
      #1;
      checks++;
      if (wr_ready !== 1 || ram_we !== 1 || ram_addr !== AW'(3) || ram_wdata !== 3'b110) begin
         errors++;
         $display("FAIL contention_write: ready=%b we=%b addr=%0d wdata=%0d, expected ready=1 we=1 addr=3 wdata=6", wr_ready, ram_we, ram_addr, ram_wdata);
      end
      @(negedge clk);
      wr_valid = 0;
      shadow[3] = 3'b110;
      disp_req = 1; video_on = 0; disp_addr = AW'(4);
      #1;
      checks++;
      if (wr_ready !== 1 || ram_en !== 0) begin
         errors++;
         $display("FAIL video_off: ready=%b en=%b, expected ready=1 en=0", wr_ready, ram_en);
      end
      @(negedge clk);
      disp_req = 0; video_on = 1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      @(negedge clk); issue(3);
      @(negedge clk); issue(5);
      @(negedge clk); issue(20);
      @(negedge clk); issue(1);
      @(negedge clk); issue(0);
      @(negedge clk); disp_req = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_clear();
      int busy_n = 0, done_n = 0;
      @(negedge clk);
      clr_color = 3'b010; clr_start = 1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         clr_start = 0;
         busy_n += int'(clr_busy);
         done_n += int'(clr_done);
         if (clr_busy) begin
            checks++;
            if (wr_ready !== 0) begin
               errors++;
               $display("FAIL clear_wr_ready: wr_ready=%b during clear, expected 0", wr_ready);
            end
         end
      end
      checks++;
      if (busy_n !== 16 || done_n !== 1) begin
         errors++;
         $display("FAIL clear_timing: busy cycles=%0d done pulses=%0d, expected 16 and 1", busy_n, done_n);
      end
      for (int i = 0; i < D; i++) shadow[i] = 3'b010;
      read_all();
   endtask

   task automatic test_clear_interleaved();
      int busy_n = 0, done_n = 0;
      @(negedge clk);
      clr_color = 3'b110; clr_start = 1;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         clr_start = 0;
         done_n += int'(clr_done);
         if (clr_busy) begin
            if (busy_n % 2 == 0) issue(20);
            else disp_req = 0;
            if (busy_n == 10) begin
               clr_start = 1;
               clr_color = 3'b001;
            end
            busy_n++;
         end else disp_req = 0;
      end
      checks++;
      if (busy_n !== 32 || done_n !== 1) begin
         errors++;
         $display("FAIL clear_interleaved: busy cycles=%0d done pulses=%0d, expected 32 and 1", busy_n, done_n);
      end
      for (int i = 0; i < D; i++) shadow[i] = 3'b110;
      read_all();
   endtask

   task automatic test_reset_mid_clear();
      int busy_n = 0;
      @(negedge clk);
      clr_color = 3'b011; clr_start = 1;
      for (int n = 0; n < 40 && busy_n < 8; n++) begin
         @(negedge clk);
         clr_start = 0;
         busy_n += int'(clr_busy);
      end
      checks++;
      if (busy_n !== 8) begin
         errors++;
         $display("FAIL clear_progress: busy cycles=%0d, expected 8 before abort", busy_n);
      end
      reset = 1;
      #1;
      checks++;
      if (clr_busy !== 0 || clr_done !== 0 || ram_en !== 0) begin
         errors++;
         $display("FAIL abort_now: busy=%b done=%b en=%b, expected 0 0 0", clr_busy, clr_done, ram_en);
      end
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      checks++;
      if (clr_busy !== 0 || clr_done !== 0) begin
         errors++;
         $display("FAIL abort_after: busy=%b done=%b, expected 0 0", clr_busy, clr_done);
      end
      for (int i = 0; i < 7; i++) shadow[i] = 3'b011;
      read_all();
      @(negedge clk); issue(5);
      @(negedge clk); issue(20);
      @(negedge clk); disp_req = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_vblank();
      @(negedge clk);
      vblank = 0; wr_valid = 1; wr_addr = AW'(9); wr_data = 3'b111;
      #1;
`ifdef VBLANK_ONLY_WR_EN
      checks++;
      if (wr_ready !== 0 || ram_en !== 0) begin
         errors++;
         $display("FAIL vblank_low: ready=%b en=%b, expected 0 0", wr_ready, ram_en);
      end
      @(negedge clk);
      vblank = 1;
      #1;
`endif
      checks++;
      if (wr_ready !== 1 || ram_we !== 1 || ram_addr !== AW'(9)) begin
         errors++;
         $display("FAIL vblank_write: ready=%b we=%b addr=%0d, expected 1 1 9", wr_ready, ram_we, ram_addr);
      end
      @(negedge clk);
      wr_valid = 0; vblank = 1;
      shadow[9] = 3'b111;
      @(negedge clk); issue(9);
      @(negedge clk); disp_req = 0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < D; i++) begin
         mem[i] = '0;
         shadow[i] = '0;
      end
      test_reset();
      test_write_read();
      test_contention();
      test_back_to_back();
      test_clear();
      test_clear_interleaved();
      test_reset_mid_clear();
      test_vblank();
      repeat (4) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d reads outstanding, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end
endmodule
